// File: rtl/aes_key_expansion.sv
// aes_key_expansion
//   Iterative AES-128 key schedule. Captures a 128-bit cipher key on an
//   accepted start and streams round keys 0..ROUNDS, one per accepted
//   handshake, to the encryption datapath. Each step of the schedule is
//   computed from the key currently presented, so there is only one round's
//   worth of S-box logic (4 S-box lookups) and no stored expanded schedule.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   start      request an expansion (only looked at while idle)
//   cipher_key 128-bit key, byte 0 = [127:120], word 0 = [127:96]
//   round_key  current round key, same byte/word ordering
//   round_idx  round number of round_key (0..ROUNDS)
//   rk_valid   round_key/round_idx valid
//   rk_ready   consumer takes the key when rk_valid & rk_ready
//   busy       high from accepted start until the last key is taken
//   done       one-cycle pulse after the last key is taken
module aes_key_expansion #(
  parameter int ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] cipher_key,
  output logic [127:0] round_key,
  output logic [3:0]   round_idx,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic         busy,
  output logic         done
);

  localparam logic [3:0] LAST_IDX = 4'(ROUNDS);

  // FIPS-197 forward S-box, indexed by input byte.
  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  // Round constant for the round being produced (1..10).
  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  typedef enum logic {IDLE, EMIT} state_t;

  state_t state, stateNext;

  logic [127:0] keyNext;
  logic [3:0]   idxNext;
  logic         validNext, busyNext, doneNext;

  // One schedule step: next(round_key, round_idx+1)
  logic [31:0]      w0, w1, w2, w3;
  logic [3:0][7:0]  rotWord, subWord;
  logic [31:0]      tWord, n0, n1, n2, n3;
  logic [3:0]       idxInc;
  logic [127:0]     stepKey;

  assign w0      = round_key[127:96];
  assign w1      = round_key[95:64];
  assign w2      = round_key[63:32];
  assign w3      = round_key[31:0];
  assign rotWord = {w3[23:0], w3[31:24]};
  assign idxInc  = round_idx + 4'd1;

  for (genvar i = 0; i < 4; i++) begin : gSub
    assign subWord[i] = sbox(rotWord[i]);
  end

  assign tWord   = subWord ^ {rcon(idxInc), 24'h0};
  assign n0      = w0 ^ tWord;
  assign n1      = w1 ^ n0;
  assign n2      = w2 ^ n1;
  assign n3      = w3 ^ n2;
  assign stepKey = {n0, n1, n2, n3};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      round_key <= '0;
      round_idx <= '0;
      rk_valid  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= stateNext;
      round_key <= keyNext;
      round_idx <= idxNext;
      rk_valid  <= validNext;
      busy      <= busyNext;
      done      <= doneNext;
    end
  end

  always_comb begin
    stateNext = state;
    keyNext   = round_key;
    idxNext   = round_idx;
    validNext = rk_valid;
    busyNext  = busy;
    doneNext  = 1'b0;
    case (state)
      IDLE: begin
        validNext = 1'b0;
        busyNext  = 1'b0;
        if (start) begin
          keyNext   = cipher_key;
          idxNext   = 4'd0;
          validNext = 1'b1;
          busyNext  = 1'b1;
          stateNext = EMIT;
        end
      end
      EMIT: begin
        // Without a handshake the presented key/index are simply held.
        if (rk_ready) begin
          if (round_idx < LAST_IDX) begin
            keyNext = stepKey;
            idxNext = idxInc;
          end else begin
            // Last key taken: key/index stay as the final round's values.
            validNext = 1'b0;
            busyNext  = 1'b0;
            doneNext  = 1'b1;
            stateNext = IDLE;
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end

endmodule

// File: doc/aes_key_expansion.md
Name: aes_key_expansion

Overview:
- Iterative AES-128 key schedule generator.
- Sits directly upstream of the Encryption datapath.
- Takes the 128-bit CipherKey and streams the 11 round keys (round 0..10) one per cycle over a valid/ready handshake.
- The encryption rounds consume one round key per AddRoundKey step instead of expanding the key combinationally.

Parameters:
- ROUNDS, 10, index of last round key emitted; legal range 1..10 (Rcon table holds 10 entries); AES-128 requires 10.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request expansion; sampled only in IDLE
- cipher_key  input  128  key; byte 0 = [127:120], word 0 = [127:96]; captured on accepted start only
- round_key  output  128  current round key, same byte/word ordering
- round_idx  output  4  round number of round_key (0..ROUNDS)
- rk_valid  output  1  round_key/round_idx valid
- rk_ready  input  1  consumer accepts the current key when rk_valid & rk_ready
- busy  output  1  high from accepted start until the final key is accepted
- done  output  1  one-cycle pulse after the last key is accepted

Behaviour:
- Reset (async assert, any state): state=IDLE, round_key=0, round_idx=0, rk_valid=0, busy=0, done=0.
- A reset mid-expansion abandons the expansion; no done pulse is issued.
- All outputs are registered.
- State IDLE:
  - rk_valid=0, busy=0.
  - On start=1: round_key<=cipher_key, round_idx<=0, rk_valid<=1, busy<=1, go EMIT.
- State EMIT:
  - rk_valid=1; round_key/round_idx held stable while rk_ready=0 (no change, no drop).
  - Handshake with round_idx<ROUNDS:
    - round_key<=next(round_key, round_idx+1);
    - round_idx<=round_idx+1;
    - rk_valid remains 1, so a new key is presented the next cycle.
  - Handshake with round_idx==ROUNDS:
    - rk_valid<=0, busy<=0, done<=1 for exactly one cycle;
    - go IDLE;
    - round_key/round_idx keep their last values.
- Timing:
  - Start accepted at edge N gives round 0 valid after edge N.
  - With rk_ready tied high, round r is visible in cycle N+1+r.
  - done is high in cycle N+2+ROUNDS.
- start while busy=1 is ignored. cipher_key changes while busy have no effect.
- A start asserted in the same cycle as done pulses is accepted, because the state is IDLE at that edge. Back-to-back expansions therefore have a 1-cycle gap after the last key.
- next(K, r), with words w0..w3 of K:
  - t = SubWord(RotWord(w3)) ^ {Rcon[r],24'h0}.
  - RotWord: [b0,b1,b2,b3] becomes [b1,b2,b3,b0].
  - SubWord applies the AES S-box (FIPS-197) to each byte. The S-box is a 256-entry constant function inside this module; 4 instances are used.
  - Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
  - n0=w0^t, n1=w1^n0, n2=w2^n1, n3=w3^n2.
- All XOR is bitwise over 32 bits; no carries. Only one round step is computed per cycle.

Test Plan:
- FIPS vector: key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1, pulse start -> round 0 = key; round 1 = a0fafe1788542cb123a339392a6c7605; round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6; round_idx 0..10 on consecutive cycles; done pulses once, 1 cycle after round 10; busy then low.
- Zero key 0 -> round 1 = 62636363626363636263636362636363; round 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- Backpressure: FIPS key, rk_ready toggled with a random pattern including a 5-cycle low at round 4 -> round_key/round_idx stable while not ready; same 11-key sequence as the first test; no key skipped or repeated.
- start pulsed with key 0 during a FIPS-key expansion -> ignored; the sequence still matches the FIPS vector; a single done.
- Assert rst during round 6 -> rk_valid, busy, done, round_key and round_idx all 0 immediately (async); no done. A fresh start after release yields round 0 correctly.
- start held high continuously -> expansions repeat with round 0 reappearing exactly 2 cycles after the previous round 10 was accepted, and done high in the intervening cycle.
